wb_stage: RTL and testbench

//   Writeback stage feeding the register file write port (reg_waddr/reg_wdata/reg_wen).

---
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and in-order load responses into one regfile write port.
// Optional load-blocked performance counter is enabled by defining WB_PERF_EN.
module wb_stage #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_waddr_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    input  logic            ld_issue_i,
    input  logic [4:0]      ld_issue_rd_i,
    output logic            ld_issue_ready_o,
    input  logic            ld_resp_valid_i,
    input  logic [XLEN-1:0] ld_resp_data_i,
    output logic            ld_resp_ready_o,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic [4:0]      id_rd_i,
    output logic            stall_o,
    output logic            reg_wen_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o
`ifdef WB_PERF_EN
    ,
    output logic [31:0]     ld_block_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      tag_mem [DEPTH];
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]   count_reg, count_next;

    logic            reg_wen_reg, reg_wen_next;
    logic [4:0]      reg_waddr_reg, reg_waddr_next;
    logic [XLEN-1:0] reg_wdata_reg, reg_wdata_next;

    logic            push;
    logic            pop;
    logic [4:0]      head_rd;
    logic [DEPTH-1:0] entry_hit;

    assign ld_issue_ready_o = (count_reg != CW'(DEPTH));
    assign ld_resp_ready_o  = (count_reg != '0) && !alu_valid_i;

    assign push    = ld_issue_i && ld_issue_ready_o;
    assign pop     = ld_resp_valid_i && ld_resp_ready_o;
    assign head_rd = tag_mem[rd_ptr_reg];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Tag storage needs no reset: validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= ld_issue_rd_i;
        end
    end

    // An entry is live when its distance from the head is below count; the head
    // stays live during its pop cycle because count only drops afterwards.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
            logic [PW-1:0] offset;
            logic          live;
            assign offset = PW'(gi) - rd_ptr_reg;
            assign live   = ({1'b0, offset} < count_reg);
            assign entry_hit[gi] = live && (tag_mem[gi] != 5'd0) &&
                                   ((tag_mem[gi] == id_rs1_i) ||
                                    (tag_mem[gi] == id_rs2_i) ||
                                    (tag_mem[gi] == id_rd_i));
        end
    endgenerate

    assign stall_o = |entry_hit;

    // ALU wins the port; a load response is only accepted when the ALU is idle.
    always_comb begin
        reg_wen_next   = 1'b0;
        reg_waddr_next = reg_waddr_reg;
        reg_wdata_next = reg_wdata_reg;
        if (alu_valid_i) begin
            reg_wen_next   = (alu_waddr_i != 5'd0);
            reg_waddr_next = alu_waddr_i;
            reg_wdata_next = alu_wdata_i;
        end else if (pop) begin
            reg_wen_next   = (head_rd != 5'd0);
            reg_waddr_next = head_rd;
            reg_wdata_next = ld_resp_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wen_reg   <= 1'b0;
            reg_waddr_reg <= '0;
            reg_wdata_reg <= '0;
        end else begin
            reg_wen_reg   <= reg_wen_next;
            reg_waddr_reg <= reg_waddr_next;
            reg_wdata_reg <= reg_wdata_next;
        end
    end

    assign reg_wen_o   = reg_wen_reg;
    assign reg_waddr_o = reg_waddr_reg;
    assign reg_wdata_o = reg_wdata_reg;

`ifdef WB_PERF_EN
    logic [31:0] ld_block_cnt_reg;

    // Counts cycles a response was offered for an outstanding load but lost to the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_block_cnt_reg <= '0;
        end else if (ld_resp_valid_i && !ld_resp_ready_o && (count_reg != '0)) begin
            ld_block_cnt_reg <= ld_block_cnt_reg + 32'd1;
        end
    end

    assign ld_block_cnt_o = ld_block_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard testbench for wb_stage: directed scenarios followed by randomized traffic
// against a queue-based reference model.
module tb_wb_stage;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_valid_i = 1'b0;
    logic [4:0]      alu_waddr_i = '0;
    logic [XLEN-1:0] alu_wdata_i = '0;
    logic            ld_issue_i = 1'b0;
    logic [4:0]      ld_issue_rd_i = '0;
    logic            ld_issue_ready_o;
    logic            ld_resp_valid_i = 1'b0;
    logic [XLEN-1:0] ld_resp_data_i = '0;
    logic            ld_resp_ready_o;
    logic [4:0]      id_rs1_i = '0;
    logic [4:0]      id_rs2_i = '0;
    logic [4:0]      id_rd_i = '0;
    logic            stall_o;
    logic            reg_wen_o;
    logic [4:0]      reg_waddr_o;
    logic [XLEN-1:0] reg_wdata_o;
`ifdef WB_PERF_EN
    logic [31:0]     ld_block_cnt_o;
`endif

    wb_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_valid_i      (alu_valid_i),
        .alu_waddr_i      (alu_waddr_i),
        .alu_wdata_i      (alu_wdata_i),
        .ld_issue_i       (ld_issue_i),
        .ld_issue_rd_i    (ld_issue_rd_i),
        .ld_issue_ready_o (ld_issue_ready_o),
        .ld_resp_valid_i  (ld_resp_valid_i),
        .ld_resp_data_i   (ld_resp_data_i),
        .ld_resp_ready_o  (ld_resp_ready_o),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_rd_i          (id_rd_i),
        .stall_o          (stall_o),
        .reg_wen_o        (reg_wen_o),
        .reg_waddr_o      (reg_waddr_o),
        .reg_wdata_o      (reg_wdata_o)
`ifdef WB_PERF_EN
        ,
        .ld_block_cnt_o   (ld_block_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    int    n_total = 0;
    int    n_pass  = 0;
    int    pend[$];      // destinations of outstanding loads, oldest first
    wr_t   exp_q[$];     // register writes expected, in order
    int    blk_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit model_stall(input int rs1, input int rs2, input int rd);
        foreach (pend[i]) begin
            if (pend[i] != 0 && (pend[i] == rs1 || pend[i] == rs2 || pend[i] == rd)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit is_pending(input int r);
        foreach (pend[i]) if (pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle of stimulus: drive, check combinational outputs, advance model.
    task automatic step(input bit av, input int aa, input logic [31:0] ad,
                        input bit iv, input int ir,
                        input bit rv, input logic [31:0] rd_data,
                        input int rs1, input int rs2, input int rdd);
        bit issue_ok, resp_ok, accept;
        wr_t w;
        @(negedge clk);
        alu_valid_i     = av;
        alu_waddr_i     = 5'(aa);
        alu_wdata_i     = ad;
        ld_issue_i      = iv;
        ld_issue_rd_i   = 5'(ir);
        ld_resp_valid_i = rv;
        ld_resp_data_i  = rd_data;
        id_rs1_i        = 5'(rs1);
        id_rs2_i        = 5'(rs2);
        id_rd_i         = 5'(rdd);
        #1;
        issue_ok = (pend.size() != DEPTH);
        resp_ok  = (pend.size() != 0) && !av;
        accept   = rv && resp_ok;
        chk("issue_ready", {31'b0, ld_issue_ready_o}, {31'b0, issue_ok});
        chk("resp_ready", {31'b0, ld_resp_ready_o}, {31'b0, resp_ok});
        chk("stall", {31'b0, stall_o}, {31'b0, model_stall(rs1, rs2, rdd)});
`ifdef WB_PERF_EN
        chk("block_cnt", ld_block_cnt_o, blk_cnt);
        if (rv && !resp_ok && pend.size() != 0) blk_cnt++;
`endif
        if (av) begin
            if (aa != 0) begin
                w.addr = 5'(aa); w.data = ad; exp_q.push_back(w);
            end
        end else if (accept) begin
            if (pend[0] != 0) begin
                w.addr = 5'(pend[0]); w.data = rd_data; exp_q.push_back(w);
            end
        end
        if (accept) void'(pend.pop_front());
        if (iv && issue_ok) pend.push_back(ir);
    endtask

    task automatic idle(input int rs1, input int rs2, input int rdd);
        step(0, 0, 0, 0, 0, 0, 0, rs1, rs2, rdd);
    endtask

    // Write monitor: every enabled write must match the oldest expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && reg_wen_o) begin
                if (exp_q.size() == 0) begin
                    chk("wr_spurious", {31'b0, reg_wen_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("wr x%0d = %h (expected x%0d = %h)", reg_waddr_o, reg_wdata_o, e.addr, e.data);
                    chk("wr_addr", {27'b0, reg_waddr_o}, {27'b0, e.addr});
                    chk("wr_data", reg_wdata_o, e.data);
                end
            end
        end
    end

    initial begin
        int aa, ir, r1, r2, r3;
        bit av, iv, rv;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_wen", {31'b0, reg_wen_o}, 32'd0);
        chk("rst_waddr", {27'b0, reg_waddr_o}, 32'd0);
        chk("rst_wdata", reg_wdata_o, 32'd0);
        chk("rst_resp_ready", {31'b0, ld_resp_ready_o}, 32'd0);
        rst = 1'b0;

        // 1: ALU write
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // 2: two loads, in-order responses
        step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 7, 0, 0, 3, 7, 0);
        step(0, 0, 0, 0, 0, 1, 32'hAA, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hBB, 0, 0, 7);
        idle(3, 7, 0);
        // 3: fill, 5th ignored, drain one
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 10 + i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 10);
        idle(0, 0, 14);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 32'h200 + i, 11, 12, 13);
        idle(0, 0, 0);
        // 4: stall on rd=9, released after pop
        step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h99, 0, 9, 0);
        idle(0, 9, 0);
        // 5: ALU beats load response
        step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        step(1, 6, 32'h66, 0, 0, 1, 32'h44, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h44, 0, 0, 0);
        idle(0, 0, 0);
        // 6: load to x0, then async reset with two pending
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0);
        idle(0, 0, 0);
        step(0, 0, 0, 1, 11, 0, 0, 0, 0, 0);
        step(1, 2, 32'h22, 1, 12, 0, 0, 0, 0, 0);
        idle(0, 0, 11);
        #2 rst = 1'b1;
        #1;
        chk("arst_wen", {31'b0, reg_wen_o}, 32'd0);
        chk("arst_waddr", {27'b0, reg_waddr_o}, 32'd0);
        chk("arst_wdata", reg_wdata_o, 32'd0);
        chk("arst_stall", {31'b0, stall_o}, 32'd0);
        chk("arst_resp_ready", {31'b0, ld_resp_ready_o}, 32'd0);
        pend.delete();
        exp_q.delete();
        blk_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(0, 0, 12);

        // randomized traffic with small register range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            av = ($urandom_range(0, 2) == 0);
            aa = $urandom_range(0, 7);
            if (av && is_pending(aa)) av = 1'b0;
            iv = $urandom_range(0, 1);
            ir = $urandom_range(0, 7);
            rv = ($urandom_range(0, 2) != 0);
            r1 = $urandom_range(0, 7);
            r2 = $urandom_range(0, 7);
            r3 = $urandom_range(0, 7);
            step(av, aa, $urandom, iv, ir, rv, $urandom, r1, r2, r3);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 1, $urandom, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        chk("exp_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
